// File: rtl/mips_pkg.sv
// Shared fetch-side definitions: default widths, PC increment, fetch FSM states
// and the {pc, instr} queue entry layout.
package mips_pkg;

  localparam int ADDR_W_DFLT = 32;
  localparam int DATA_W_DFLT = 32;
  localparam int PC_STEP     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_W_DFLT-1:0] pc;
    logic [DATA_W_DFLT-1:0] instr;
  } if_entry_t;

endpackage

// File: rtl/if_queue.sv
// Two-entry synchronous FIFO holding fetched {pc, instr} words.
// Flush empties it at the next edge; the head reads as zero when empty.
module if_queue
  import mips_pkg::*;
#(
  parameter int W     = 64,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  input  logic         flush,
  output logic [1:0]   count,
  output logic [W-1:0] head
);

  generate
    if (DEPTH != 2) begin : g_depth_check
      $error("if_queue supports exactly 2 entries");
    end
  endgenerate

  logic       rd_ptr_reg;
  logic       wr_ptr_reg;
  logic [1:0] count_reg;
  logic       do_push;
  logic       do_pop;

  assign do_pop  = pop && (count_reg != 2'd0);
  assign do_push = push && (count_reg != 2'd2);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      logic [W-1:0] entry_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          entry_reg <= '0;
        end else if (do_push && !flush && (wr_ptr_reg == 1'(gi))) begin
          entry_reg <= push_data;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr_reg <= 1'b0;
      wr_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (do_push) wr_ptr_reg <= ~wr_ptr_reg;
      if (do_pop)  rd_ptr_reg <= ~rd_ptr_reg;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign count = count_reg;
  assign head  = (count_reg == 2'd0) ? '0 :
                 (rd_ptr_reg ? g_entry[1].entry_reg : g_entry[0].entry_reg);

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch front end: issues one imem read per PC, steers the PC register
// (+4 or redirect) and queues {pc, instr} for decode. IF_PERF_CNT_EN adds stall/flush counters.
module inst_fetch
  import mips_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DFLT,
  parameter int DATA_W  = DATA_W_DFLT,
  parameter int Q_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_in,
  output logic [ADDR_W-1:0] pc_next,
  output logic              pc_ena,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
`ifdef IF_PERF_CNT_EN
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt,
`endif
  input  logic              if_ready
);

  fetch_state_e              state_reg;
  logic                      drop_reg;
  logic [ADDR_W-1:0]         req_pc_reg;
  logic [1:0]                q_count;
  logic [ADDR_W+DATA_W-1:0]  q_head;
  logic                      fetch_fire;
  logic                      q_push;
  logic                      q_pop;

  // Redirect suppresses issue so the stale PC never reaches memory.
  assign imem_addr  = pc_in;
  assign imem_req   = !rst && (state_reg == REQ) && (q_count < 2'd2) && !redirect;
  assign fetch_fire = imem_req && imem_gnt;
  assign pc_ena     = !rst && (redirect || fetch_fire);

  always_comb begin
    pc_next = '0;
    if (!rst) begin
      if (redirect)        pc_next = redirect_pc;
      else if (fetch_fire) pc_next = pc_in + ADDR_W'(PC_STEP);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      drop_reg   <= 1'b0;
      req_pc_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: state_reg <= REQ;
        REQ: begin
          if (fetch_fire) begin
            req_pc_reg <= pc_in;
            state_reg  <= WAIT;
          end
        end
        WAIT: begin
          // A response always retires the outstanding read, stale or not.
          if (imem_rvalid) begin
            drop_reg  <= 1'b0;
            state_reg <= REQ;
          end else if (redirect) begin
            drop_reg <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign q_push = (state_reg == WAIT) && imem_rvalid && !drop_reg && !redirect;
  assign q_pop  = if_valid && if_ready;

  if_queue #(
    .W     (ADDR_W + DATA_W),
    .DEPTH (Q_DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (q_push),
    .push_data ({req_pc_reg, imem_rdata}),
    .pop       (q_pop),
    .flush     (redirect),
    .count     (q_count),
    .head      (q_head)
  );

  assign if_valid           = (q_count != 2'd0);
  assign {if_pc, if_instr}  = q_head;

`ifdef IF_PERF_CNT_EN
  logic [31:0] stall_cnt_reg;
  logic [31:0] flush_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (if_ready && !if_valid && (stall_cnt_reg != '1)) stall_cnt_reg <= stall_cnt_reg + 32'd1;
      if (redirect && (flush_cnt_reg != '1))              flush_cnt_reg <= flush_cnt_reg + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Testbench for inst_fetch: directed scenarios plus a randomized run checked
// against a program-order model of the delivered {pc, instr} stream.
`timescale 1ns/1ps
module tb_inst_fetch;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_in = '0;
  logic [31:0] pc_next;
  logic        pc_ena;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready = 1'b0;
`ifdef IF_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  int          total = 0;
  int          bad = 0;
  logic        pc_ena_q = 1'b0;
  logic [31:0] pc_next_q = '0;

  inst_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .pc_in       (pc_in),
    .pc_next     (pc_next),
    .pc_ena      (pc_ena),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
`ifdef IF_PERF_CNT_EN
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt),
`endif
    .if_ready    (if_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  // Memory contents seen by the bench: a fixed word per address.
  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return 32'h2408_0001 ^ {pc[15:0], pc[15:0]};
  endfunction

  // Start of a cycle: the bench-side PC register takes the value enabled last cycle.
  task automatic step_begin();
    @(negedge clk);
    if (pc_ena_q) pc_in = pc_next_q;
    pc_ena_q    = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    redirect    = 1'b0;
  endtask

  task automatic settle();
    #1;
    pc_ena_q  = pc_ena;
    pc_next_q = pc_next;
  endtask

  task automatic apply_reset();
    rst = 1'b1; if_ready = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
    redirect = 1'b0; pc_in = '0; pc_ena_q = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; if_ready = 1'b1; imem_gnt = 1'b1; imem_rvalid = 1'b0;
    redirect = 1'b0; pc_in = 32'h1234; pc_ena_q = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk); #1;
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req: got %0h want 0", imem_req); end
    total++; if (pc_ena !== 1'b0) begin bad++; $display("FAIL rst_pc_ena: got %0h want 0", pc_ena); end
    total++; if (pc_next !== 32'h0) begin bad++; $display("FAIL rst_pc_next: got %h want 0", pc_next); end
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL rst_if_valid: got %0h want 0", if_valid); end
    total++; if (if_instr !== 32'h0) begin bad++; $display("FAIL rst_if_instr: got %h want 0", if_instr); end
    total++; if (if_pc !== 32'h0) begin bad++; $display("FAIL rst_if_pc: got %h want 0", if_pc); end
`ifdef IF_PERF_CNT_EN
    total++; if (stall_cnt !== 32'h0) begin bad++; $display("FAIL rst_stall_cnt: got %0d want 0", stall_cnt); end
`endif
    @(posedge clk); #1;
    rst = 1'b0; if_ready = 1'b0; imem_gnt = 1'b0; pc_in = '0;
    $display("reset: outputs checked");
  endtask

  task automatic test_basic();
    apply_reset();
    step_begin(); settle();
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL basic_idle_req: got %0h want 0", imem_req); end
    step_begin(); imem_gnt = 1'b1; settle();
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL basic_req: got %0h want 1", imem_req); end
    total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL basic_addr: got %h want 0", imem_addr); end
    total++; if (pc_ena !== 1'b1) begin bad++; $display("FAIL basic_pc_ena: got %0h want 1", pc_ena); end
    total++; if (pc_next !== 32'h4) begin bad++; $display("FAIL basic_pc_next: got %h want 4", pc_next); end
    step_begin(); imem_rvalid = 1'b1; imem_rdata = 32'h2408_0001; settle();
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid: got %0h want 0", if_valid); end
    step_begin(); if_ready = 1'b1; settle();
    total++; if (if_valid !== 1'b1) begin bad++; $display("FAIL basic_valid: got %0h want 1", if_valid); end
    total++; if (if_pc !== 32'h0) begin bad++; $display("FAIL basic_if_pc: got %h want 0", if_pc); end
    total++; if (if_instr !== 32'h2408_0001) begin bad++; $display("FAIL basic_if_instr: got %h want 24080001", if_instr); end
    step_begin(); if_ready = 1'b0; settle();
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL basic_popped: got %0h want 0", if_valid); end
    $display("basic: pc=0 instr=24080001 delivered");
  endtask

  task automatic test_backpressure();
    apply_reset();
    step_begin(); settle();
    step_begin(); imem_gnt = 1'b1; settle();
    step_begin(); imem_rvalid = 1'b1; imem_rdata = instr_of(32'h0); settle();
    step_begin(); imem_gnt = 1'b1; settle();
    total++; if (imem_addr !== 32'h4) begin bad++; $display("FAIL bp_addr4: got %h want 4", imem_addr); end
    step_begin(); imem_rvalid = 1'b1; imem_rdata = instr_of(32'h4); settle();
    for (int i = 0; i < 2; i++) begin
      step_begin(); imem_gnt = 1'b1; settle();
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL bp_full_req: got %0h want 0", imem_req); end
      total++; if (pc_ena !== 1'b0) begin bad++; $display("FAIL bp_full_pc_ena: got %0h want 0", pc_ena); end
      total++; if (if_pc !== 32'h0) begin bad++; $display("FAIL bp_head_pc: got %h want 0", if_pc); end
    end
    step_begin(); if_ready = 1'b1; settle();
    total++; if (if_instr !== instr_of(32'h0)) begin bad++; $display("FAIL bp_pop_instr: got %h want %h", if_instr, instr_of(32'h0)); end
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL bp_pop_req: got %0h want 0", imem_req); end
    step_begin(); if_ready = 1'b0; imem_gnt = 1'b1; settle();
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL bp_resume_req: got %0h want 1", imem_req); end
    total++; if (imem_addr !== 32'h8) begin bad++; $display("FAIL bp_resume_addr: got %h want 8", imem_addr); end
    total++; if (if_pc !== 32'h4) begin bad++; $display("FAIL bp_second_pc: got %h want 4", if_pc); end
    total++; if (pc_next !== 32'hC) begin bad++; $display("FAIL bp_pc_next: got %h want c", pc_next); end
    $display("backpressure: queue held pc 0,4; resumed at 8");
  endtask

  task automatic test_grant_stall();
    apply_reset();
    step_begin(); pc_in = 32'h40; settle();
    for (int i = 0; i < 3; i++) begin
      step_begin(); settle();
      total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL gs_req: got %0h want 1", imem_req); end
      total++; if (imem_addr !== 32'h40) begin bad++; $display("FAIL gs_addr: got %h want 40", imem_addr); end
      total++; if (pc_ena !== 1'b0) begin bad++; $display("FAIL gs_pc_ena: got %0h want 0", pc_ena); end
    end
    step_begin(); imem_gnt = 1'b1; settle();
    total++; if (pc_ena !== 1'b1) begin bad++; $display("FAIL gs_grant_ena: got %0h want 1", pc_ena); end
    total++; if (pc_next !== 32'h44) begin bad++; $display("FAIL gs_pc_next: got %h want 44", pc_next); end
    step_begin(); imem_rvalid = 1'b1; imem_rdata = instr_of(32'h40); settle();
    step_begin(); settle();
    total++; if (if_pc !== 32'h40) begin bad++; $display("FAIL gs_if_pc: got %h want 40", if_pc); end
    $display("grant_stall: pc=40 held 3 cycles then granted");
  endtask

  task automatic test_redirect_wait();
    apply_reset();
    step_begin(); settle();
    step_begin(); imem_gnt = 1'b1; settle();
    step_begin(); imem_rvalid = 1'b1; imem_rdata = instr_of(32'h0); settle();
    step_begin(); imem_gnt = 1'b1; settle();
    step_begin(); redirect = 1'b1; redirect_pc = 32'h100; settle();
    total++; if (pc_ena !== 1'b1) begin bad++; $display("FAIL rw_pc_ena: got %0h want 1", pc_ena); end
    total++; if (pc_next !== 32'h100) begin bad++; $display("FAIL rw_pc_next: got %h want 100", pc_next); end
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rw_req: got %0h want 0", imem_req); end
    step_begin(); settle();
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL rw_flushed: got %0h want 0", if_valid); end
    step_begin(); imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; settle();
    step_begin(); settle();
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL rw_dropped: got %0h want 0", if_valid); end
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL rw_req_after: got %0h want 1", imem_req); end
    total++; if (imem_addr !== 32'h100) begin bad++; $display("FAIL rw_addr_after: got %h want 100", imem_addr); end
    $display("redirect_wait: target=100 stale response dropped");
  endtask

  task automatic test_redirect_rvalid_pop();
    apply_reset();
    step_begin(); settle();
    step_begin(); imem_gnt = 1'b1; settle();
    step_begin(); imem_rvalid = 1'b1; imem_rdata = instr_of(32'h0); settle();
    step_begin(); imem_gnt = 1'b1; settle();
    step_begin(); redirect = 1'b1; redirect_pc = 32'h200;
    imem_rvalid = 1'b1; imem_rdata = instr_of(32'h4); if_ready = 1'b1; settle();
    total++; if (if_pc !== 32'h0) begin bad++; $display("FAIL rrp_pop_pc: got %h want 0", if_pc); end
    total++; if (pc_next !== 32'h200) begin bad++; $display("FAIL rrp_pc_next: got %h want 200", pc_next); end
    step_begin(); if_ready = 1'b0; imem_gnt = 1'b1; settle();
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL rrp_empty: got %0h want 0", if_valid); end
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL rrp_req: got %0h want 1", imem_req); end
    total++; if (imem_addr !== 32'h200) begin bad++; $display("FAIL rrp_addr: got %h want 200", imem_addr); end
    step_begin(); imem_rvalid = 1'b1; imem_rdata = instr_of(32'h200); settle();
    step_begin(); imem_gnt = 1'b1; settle();
    total++; if (if_pc !== 32'h200) begin bad++; $display("FAIL rrp_nodrop_pc: got %h want 200", if_pc); end
    step_begin(); imem_rvalid = 1'b1; imem_rdata = instr_of(32'h204); settle();
    step_begin(); redirect = 1'b1; redirect_pc = 32'h300; if_ready = 1'b1; settle();
    total++; if (if_pc !== 32'h200) begin bad++; $display("FAIL rrp_full_pop: got %h want 200", if_pc); end
    step_begin(); if_ready = 1'b0; settle();
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL rrp_full_flush: got %0h want 0", if_valid); end
    $display("redirect_rvalid_pop: pop honoured, data dropped, flushed");
  endtask

  task automatic test_wrap_perf();
    apply_reset();
    step_begin(); pc_in = 32'hFFFF_FFFC; settle();
    step_begin(); imem_gnt = 1'b1; settle();
    total++; if (pc_ena !== 1'b1) begin bad++; $display("FAIL wrap_ena: got %0h want 1", pc_ena); end
    total++; if (pc_next !== 32'h0) begin bad++; $display("FAIL wrap_pc_next: got %h want 0", pc_next); end
    $display("wrap: pc=fffffffc next=0");
`ifdef IF_PERF_CNT_EN
    apply_reset();
    total++; if (flush_cnt !== 32'h0) begin bad++; $display("FAIL perf_flush0: got %0d want 0", flush_cnt); end
    if_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin step_begin(); settle(); end
    step_begin(); if_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h80; settle();
    total++; if (stall_cnt !== 32'd5) begin bad++; $display("FAIL perf_stall: got %0d want 5", stall_cnt); end
    step_begin(); settle();
    total++; if (flush_cnt !== 32'd1) begin bad++; $display("FAIL perf_flush: got %0d want 1", flush_cnt); end
    $display("perf: stall_cnt=%0d flush_cnt=%0d", stall_cnt, flush_cnt);
`endif
  endtask

  // Delivered instructions must follow program order: +4 from the last one,
  // restarting at each redirect target, with the word stored at that address.
  task automatic test_random();
    logic [31:0] exp_pc;
    logic        pend;
    logic [31:0] pend_addr;
    int          pend_delay;
    int          delivered;
    logic        fire_exp;
    if_entry_t   ent;
    apply_reset();
    exp_pc = '0; pend = 1'b0; pend_addr = '0; pend_delay = 0; delivered = 0;
    for (int c = 0; c < 800; c++) begin
      step_begin();
      if_ready = ($urandom_range(0, 9) < 6);
      imem_gnt = 1'($urandom_range(0, 1));
      if (pend) begin
        if (pend_delay == 1) begin
          imem_rvalid = 1'b1; imem_rdata = instr_of(pend_addr); pend = 1'b0;
        end else begin
          pend_delay--;
        end
      end
      if ($urandom_range(0, 19) == 0) begin
        redirect = 1'b1;
        redirect_pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom() & 32'h0000_FFFC);
      end
      settle();
      if (imem_req) begin
        total++; if (pend || imem_rvalid) begin bad++; $display("FAIL rnd_outstanding: got 2 reads want 1 (cycle %0d)", c); end
        total++; if (imem_addr !== pc_in) begin bad++; $display("FAIL rnd_addr: got %h want %h", imem_addr, pc_in); end
      end
      fire_exp = redirect || (imem_req && imem_gnt);
      total++; if (pc_ena !== fire_exp) begin bad++; $display("FAIL rnd_pc_ena: got %0h want %0h (cycle %0d)", pc_ena, fire_exp, c); end
      if (redirect) begin
        total++; if (pc_next !== redirect_pc) begin bad++; $display("FAIL rnd_redir_next: got %h want %h", pc_next, redirect_pc); end
      end else if (fire_exp) begin
        total++; if (pc_next !== pc_in + 32'd4) begin bad++; $display("FAIL rnd_seq_next: got %h want %h", pc_next, pc_in + 32'd4); end
      end
      if (imem_req && imem_gnt) begin
        pend = 1'b1; pend_addr = pc_in; pend_delay = $urandom_range(1, 3);
      end
      if (if_valid && if_ready) begin
        ent = '{pc: if_pc, instr: if_instr};
        $display("deliver pc=%h instr=%h", ent.pc, ent.instr);
        total++; if (ent.pc !== exp_pc) begin bad++; $display("FAIL rnd_pc: got %h want %h", ent.pc, exp_pc); end
        total++; if (ent.instr !== instr_of(exp_pc)) begin bad++; $display("FAIL rnd_instr: got %h want %h", ent.instr, instr_of(exp_pc)); end
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end
      if (redirect) exp_pc = redirect_pc;
    end
    total++; if (delivered < 50) begin bad++; $display("FAIL rnd_progress: got %0d want >=50 deliveries", delivered); end
    if_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_grant_stall();
    test_redirect_wait();
    test_redirect_rvalid_pop();
    test_wrap_perf();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
